// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package mem_lsu_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned STRB_W = XLEN / 8;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_type_e;

  typedef enum logic [3:0] {
    MCAUSE_NONE        = 4'd0,
    MCAUSE_LD_MISALIGN = 4'd4,
    MCAUSE_ST_MISALIGN = 4'd6
  } csr_mcause_e;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_RESP,
    LSU_DONE
  } lsu_state_e;

  // funct3[1:0] access size
  localparam logic [1:0] LSU_B = 2'd0;
  localparam logic [1:0] LSU_H = 2'd1;
  localparam logic [1:0] LSU_W = 2'd2;
  localparam logic [1:0] LSU_D = 2'd3;

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic              we;
    logic [STRB_W-1:0] wstrb;
    logic [XLEN-1:0]   wdata;
  } dmem_req_t;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] lsu_low_mask(input logic [1:0] size);
    return 3'((4'd1 << size) - 4'd1);
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory bus: valid/ready request channel plus response-valid return.
interface mem_lsu_if;

  logic                                 valid;
  logic                                 ready;
  logic [mem_lsu_pkg::XLEN-1:0]         addr;
  logic                                 we;
  logic [mem_lsu_pkg::STRB_W-1:0]       wstrb;
  logic [mem_lsu_pkg::XLEN-1:0]         wdata;
  logic                                 rvalid;
  logic [mem_lsu_pkg::XLEN-1:0]         rdata;

  modport master (
    output valid, addr, we, wstrb, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, addr, we, wstrb, wdata,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/mem_lsu_align.sv
// Lane steering: store strobe/data replication and load lane extract + extend.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [2:0]        offset,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [STRB_W-1:0] wstrb_c,
  output logic [XLEN-1:0]   wdata_c,
  output logic [XLEN-1:0]   rdata_c
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    wstrb_c = '0;
    wdata_c = '0;
    rdata_c = '0;
    shifted = rdata >> {offset, 3'b000};
    case (size)
      LSU_B: begin
        wstrb_c = STRB_W'(8'h01) << offset;
        wdata_c = {(XLEN/8){wdata[7:0]}};
        rdata_c = is_unsigned ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                              : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      end
      LSU_H: begin
        wstrb_c = STRB_W'(8'h03) << offset;
        wdata_c = {(XLEN/16){wdata[15:0]}};
        rdata_c = is_unsigned ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                              : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      end
      LSU_W: begin
        wstrb_c = STRB_W'(8'h0F) << offset;
        wdata_c = {(XLEN/32){wdata[31:0]}};
        rdata_c = is_unsigned ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                              : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      end
      LSU_D: begin
        wstrb_c = STRB_W'(8'hFF);
        wdata_c = wdata;
        rdata_c = shifted;
      end
      default: begin
        wstrb_c = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: one bus transaction per EX/MEM operation.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of masking them.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned Xlen = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  input  mem_type_e       mem_type_i,
  input  logic [2:0]      funct3_i,
  input  logic [Xlen-1:0] addr_i,
  input  logic [Xlen-1:0] wdata_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [Xlen-1:0] load_data_o,
  output logic            expt_valid_o,
  output csr_mcause_e     expt_cause_o,
  output logic [Xlen-1:0] expt_value_o,
  mem_lsu_if.master       dmem
);

  lsu_state_e  state_q, state_d;
  dmem_req_t   req_q, req_d;
  logic        valid_q, valid_d;
  logic        is_load_q, is_load_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [2:0]  off_q, off_d;
  logic        done_q, done_d;
  logic [Xlen-1:0] ld_q, ld_d;
  logic        xv_q, xv_d;
  csr_mcause_e xc_q, xc_d;
  logic [Xlen-1:0] xval_q, xval_d;

  logic              op_valid;
  logic              is_store;
  logic              trap;
  logic [1:0]        size_sel;
  logic [2:0]        off_sel;
  logic [STRB_W-1:0] st_strb;
  logic [XLEN-1:0]   st_wdata;
  logic [XLEN-1:0]   ld_ext;

  assign op_valid = req_valid_i && (mem_type_i == MEM_LOAD || mem_type_i == MEM_STORE);
  assign is_store = (mem_type_i == MEM_STORE);

  // Aligner sees the live inputs while sampling, the latched op afterwards.
  assign size_sel = (state_q == LSU_IDLE) ? funct3_i[1:0] : size_q;
  assign off_sel  = (state_q == LSU_IDLE) ? (addr_i[2:0] & ~lsu_low_mask(funct3_i[1:0])) : off_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = |(addr_i[2:0] & lsu_low_mask(funct3_i[1:0]));
`else
  assign trap = 1'b0;
`endif

  mem_lsu_align u_align (
    .size        (size_sel),
    .is_unsigned (uns_q),
    .offset      (off_sel),
    .wdata       (wdata_i),
    .rdata       (dmem.rdata),
    .wstrb_c     (st_strb),
    .wdata_c     (st_wdata),
    .rdata_c     (ld_ext)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    valid_d   = valid_q;
    is_load_d = is_load_q;
    size_d    = size_q;
    uns_d     = uns_q;
    off_d     = off_q;
    ld_d      = ld_q;
    done_d    = 1'b0;
    xv_d      = 1'b0;
    xc_d      = MCAUSE_NONE;
    xval_d    = '0;
    unique case (state_q)
      LSU_IDLE: begin
        if (op_valid) begin
          is_load_d = !is_store;
          size_d    = funct3_i[1:0];
          uns_d     = funct3_i[2];
          off_d     = off_sel;
          if (trap) begin
            state_d = LSU_DONE;
            done_d  = 1'b1;
            ld_d    = '0;
            xv_d    = 1'b1;
            xval_d  = addr_i;
            if (is_store) xc_d = MCAUSE_ST_MISALIGN;
            else          xc_d = MCAUSE_LD_MISALIGN;
          end else begin
            state_d     = LSU_REQ;
            valid_d     = 1'b1;
            req_d.addr  = {addr_i[Xlen-1:3], 3'b000};
            req_d.we    = is_store;
            req_d.wstrb = is_store ? st_strb : '0;
            req_d.wdata = is_store ? st_wdata : '0;
          end
        end
      end
      LSU_REQ: begin
        if (dmem.ready) begin
          valid_d = 1'b0;
          if (is_load_q) begin
            state_d = LSU_RESP;
          end else begin
            state_d = LSU_DONE;
            done_d  = 1'b1;
            ld_d    = '0;
          end
        end
      end
      LSU_RESP: begin
        if (dmem.rvalid) begin
          state_d = LSU_DONE;
          done_d  = 1'b1;
          ld_d    = ld_ext;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= LSU_IDLE;
      req_q     <= '0;
      valid_q   <= 1'b0;
      is_load_q <= 1'b0;
      size_q    <= 2'd0;
      uns_q     <= 1'b0;
      off_q     <= 3'd0;
      ld_q      <= '0;
      done_q    <= 1'b0;
      xv_q      <= 1'b0;
      xc_q      <= MCAUSE_NONE;
      xval_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      is_load_q <= is_load_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      off_q     <= off_d;
      ld_q      <= ld_d;
      done_q    <= done_d;
      xv_q      <= xv_d;
      xc_q      <= xc_d;
      xval_q    <= xval_d;
    end
  end

  // Stall drops with reset so a reset pipeline is never held.
  assign stall_o      = rst_ni && req_valid_i && (state_q != LSU_DONE);
  assign done_o       = done_q;
  assign load_data_o  = ld_q;
  assign expt_valid_o = xv_q;
  assign expt_cause_o = xc_q;
  assign expt_value_o = xval_q;

  assign dmem.valid = valid_q;
  assign dmem.addr  = req_q.addr;
  assign dmem.we    = req_q.we;
  assign dmem.wstrb = req_q.wstrb;
  assign dmem.wdata = req_q.wdata;

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized self-checking bench for mem_lsu against a lane-arithmetic reference model.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  mem_type_e   mem_type;
  logic [2:0]  funct3;
  logic [63:0] addr, wdata;
  logic        stall, done, expt_valid;
  logic [63:0] load_data, expt_value;
  csr_mcause_e expt_cause;
  logic [63:0] last_ld;
  int          n_vec = 0;
  int          n_err = 0;

  mem_lsu_if dmem_bus();

  always #5 clk = ~clk;

  mem_lsu #(.Xlen(64)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .mem_type_i   (mem_type),
    .funct3_i     (funct3),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .stall_o      (stall),
    .done_o       (done),
    .load_data_o  (load_data),
    .expt_valid_o (expt_valid),
    .expt_cause_o (expt_cause),
    .expt_value_o (expt_value),
    .dmem         (dmem_bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain byte arithmetic on size n and naturally aligned offset.
  function automatic int ref_off(input logic [2:0] lo, input logic [1:0] sz);
    int n;
    n = 1 << sz;
    return (int'(lo) / n) * n;
  endfunction

  function automatic bit ref_trap(input logic [2:0] lo, input logic [1:0] sz);
    int n;
    n = 1 << sz;
    return TrapEn && ((int'(lo) % n) != 0);
  endfunction

  function automatic logic [63:0] ref_mask(input int n);
    if (n == 8) return '1;
    return (64'd1 << (8 * n)) - 64'd1;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] rd, input logic [2:0] lo,
                                           input logic [2:0] f3);
    int n;
    logic [63:0] v;
    n = 1 << f3[1:0];
    v = rd >> (8 * ref_off(lo, f3[1:0]));
    if (n == 8) return v;
    v = v & ref_mask(n);
    if (!f3[2] && v[8*n-1]) v = v | ~ref_mask(n);
    return v;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] wd, input logic [1:0] sz);
    int n;
    logic [63:0] r;
    n = 1 << sz;
    r = '0;
    for (int i = 0; i < 8; i += n) r = r | ((wd & ref_mask(n)) << (8 * i));
    return r;
  endfunction

  // Runs one operation acting as the memory; in_done means it starts in a DONE cycle.
  task automatic run_op(input mem_type_e t, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, input logic [63:0] rd,
                        input int rw, input int vw, input bit in_done);
    bit ld, trap, seen, acc;
    int n, e_lat, cyc, vcnt, wcnt, rcnt;
    logic [7:0]  e_strb;
    logic [63:0] e_ld, e_cause;
    ld    = (t == MEM_LOAD);
    trap  = ref_trap(a[2:0], f3[1:0]);
    n     = 1 << f3[1:0];
    e_strb = 8'(((1 << n) - 1) << ref_off(a[2:0], f3[1:0]));
    e_lat = (trap ? 1 : (ld ? 3 + rw + vw : 2 + rw)) + (in_done ? 1 : 0);
    e_ld  = (ld && !trap) ? ref_load(rd, a[2:0], f3) : 64'd0;
    e_cause = trap ? (ld ? 64'd4 : 64'd6) : 64'd0;
    seen = 0; acc = 0; cyc = 0; vcnt = 0; wcnt = 0; rcnt = 0;
    req_valid = 1'b1; mem_type = t; funct3 = f3; addr = a; wdata = wd;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (done) begin
        seen = 1;
        chk("latency", 64'(cyc), 64'(e_lat));
        chk("stall_done", 64'(stall), 64'd0);
        chk("expt_valid", 64'(expt_valid), 64'(trap));
        chk("expt_cause", 64'(expt_cause), e_cause);
        chk("expt_value", expt_value, trap ? a : 64'd0);
        chk("load_data", load_data, e_ld);
        chk("valid_cycles", 64'(vcnt), trap ? 64'd0 : 64'(rw + 1));
        last_ld = e_ld;
      end else begin
        chk("stall", 64'(stall), 64'd1);
        chk("expt_idle", 64'(expt_valid), 64'd0);
        chk("ld_hold", load_data, last_ld);
        if (dmem_bus.valid) begin
          vcnt++;
          chk("bus_addr", dmem_bus.addr, {a[63:3], 3'b000});
          chk("bus_we", 64'(dmem_bus.we), 64'(!ld));
          if (!ld) begin
            chk("bus_wstrb", 64'(dmem_bus.wstrb), 64'(e_strb));
            chk("bus_wdata", dmem_bus.wdata, ref_wdata(wd, f3[1:0]));
          end
          dmem_bus.rvalid = 1'($urandom);
          dmem_bus.rdata  = {$urandom, $urandom};
          if (wcnt >= rw) begin
            dmem_bus.ready = 1'b1;
            acc = 1;
          end else begin
            dmem_bus.ready = 1'b0;
            wcnt++;
          end
        end else if (acc && ld) begin
          dmem_bus.ready = 1'($urandom);
          if (rcnt >= vw) begin
            dmem_bus.rvalid = 1'b1;
            dmem_bus.rdata  = rd;
          end else begin
            dmem_bus.rvalid = 1'b0;
            dmem_bus.rdata  = {$urandom, $urandom};
            rcnt++;
          end
        end else begin
          dmem_bus.ready  = 1'($urandom);
          dmem_bus.rvalid = 1'($urandom);
          dmem_bus.rdata  = {$urandom, $urandom};
        end
      end
    end
    if (!seen) chk("done_timeout", 64'(seen), 64'd1);
    dmem_bus.ready  = 1'b0;
    dmem_bus.rvalid = 1'b0;
  endtask

  task automatic idle_gap(input int g);
    req_valid = 1'b0;
    repeat (g) begin
      @(negedge clk);
      chk("gap_stall", 64'(stall), 64'd0);
      chk("gap_done", 64'(done), 64'd0);
      chk("gap_ld_hold", load_data, last_ld);
    end
  endtask

  // Reset asserted mid-transfer, in REQ or RESP; a late response must be ignored.
  task automatic reset_mid(input bit in_resp);
    req_valid = 1'b1; mem_type = MEM_LOAD; funct3 = 3'b011;
    addr = 64'h5000; wdata = '0;
    dmem_bus.ready = in_resp; dmem_bus.rvalid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_pre_valid", 64'(dmem_bus.valid), 64'd1);
    if (in_resp) begin
      @(posedge clk); @(negedge clk);
      dmem_bus.ready = 1'b0;
      chk("rst_pre_resp_valid", 64'(dmem_bus.valid), 64'd0);
      chk("rst_pre_resp_stall", 64'(stall), 64'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(dmem_bus.valid), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ld", load_data, 64'd0);
    last_ld = '0;
    @(negedge clk);
    rst_n = 1'b1; req_valid = 1'b0;
    dmem_bus.rvalid = 1'b1; dmem_bus.rdata = {$urandom, $urandom};
    repeat (3) begin
      @(negedge clk);
      chk("rst_late_done", 64'(done), 64'd0);
      chk("rst_late_ld", load_data, 64'd0);
      chk("rst_late_valid", 64'(dmem_bus.valid), 64'd0);
    end
    dmem_bus.rvalid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_type_e   t;
    logic [2:0]  f3;
    logic [63:0] a, wd, rd;
    int          gap;
    bit          prev_done;

    rst_n = 1'b0; req_valid = 1'b1; mem_type = MEM_LOAD; funct3 = 3'b000;
    addr = '0; wdata = '0; last_ld = '0;
    dmem_bus.ready = 1'b0; dmem_bus.rvalid = 1'b0; dmem_bus.rdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_valid", 64'(dmem_bus.valid), 64'd0);
    chk("reset_ld", load_data, 64'd0);
    chk("reset_expt", 64'(expt_valid), 64'd0);
    req_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);

    run_op(MEM_LOAD, 3'b000, 64'h1003, 64'd0, 64'h0000_0000_80FF_0000, 0, 0, 0);
    idle_gap(1);
    run_op(MEM_LOAD, 3'b100, 64'h1003, 64'd0, 64'h0000_0000_80FF_0000, 0, 0, 0);
    idle_gap(1);
    run_op(MEM_STORE, 3'b001, 64'h2006, 64'h1234, 64'd0, 0, 0, 0);
    idle_gap(1);
    run_op(MEM_LOAD, 3'b010, 64'h3002, 64'd0, 64'hDEAD_BEEF_8765_4321, 0, 0, 0);
    idle_gap(1);
    run_op(MEM_LOAD, 3'b011, 64'h4000, 64'd0, 64'h0123_4567_89AB_CDEF, 4, 2, 0);
    idle_gap(1);
    run_op(MEM_STORE, 3'b010, 64'h4004, 64'hCAFE_F00D_1122_3344, 64'd0, 4, 0, 0);
    idle_gap(0);
    run_op(MEM_LOAD, 3'b101, 64'h4006, 64'd0, 64'h8000_7000_6000_5000, 1, 3, 1);
    idle_gap(1);

    // Operations with no load/store type never touch the bus.
    req_valid = 1'b1; mem_type = mem_type_e'(2'd3); addr = 64'h7000;
    repeat (3) begin
      @(negedge clk);
      chk("notype_valid", 64'(dmem_bus.valid), 64'd0);
      chk("notype_done", 64'(done), 64'd0);
    end
    idle_gap(1);

    prev_done = 0;
    for (int i = 0; i < 200; i++) begin
      t  = ($urandom_range(0, 1) == 1) ? MEM_STORE : MEM_LOAD;
      f3 = 3'($urandom);
      a  = {$urandom, $urandom};
      wd = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      run_op(t, f3, a, wd, rd, $urandom_range(0, 3), $urandom_range(0, 3), prev_done);
      gap = $urandom_range(0, 2);
      idle_gap(gap);
      prev_done = (gap == 0);
    end
    idle_gap(1);

    reset_mid(1'b0);
    reset_mid(1'b1);
    run_op(MEM_LOAD, 3'b001, 64'h6002, 64'd0, 64'h1111_2222_F333_4444, 0, 0, 0);
    idle_gap(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
